// File: rtl/opl2_timer_status_if.sv
// Host bus of the OPL2 timer/status block: strobes, port select and read-back data.
interface opl2_timer_status_if;
    logic       wr;
    logic       rd;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid;

    modport master (output wr, rd, a0, din, input dout, dout_valid);
    modport slave  (input wr, rd, a0, din, output dout, dout_valid);
endinterface

// File: rtl/opl2_timer_status.sv
// OPL2 timer control/status: decodes host writes to 0x02-0x04, drives the two timer
// presets and run enables, latches overflow flags and returns the status byte and irq_n.
module opl2_timer_status #(
    parameter logic [4:0]   STATUS_LOW_BITS = 5'h06,
    localparam int unsigned REG_TIMER_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    opl2_timer_status_if.slave         host,
    input  logic                       timer1_overflow_pulse,
    input  logic                       timer2_overflow_pulse,
    output logic [REG_TIMER_WIDTH-1:0] timer1_reg,
    output logic [REG_TIMER_WIDTH-1:0] timer2_reg,
    output logic                       start_timer1,
    output logic                       start_timer2,
    output logic                       irq_n
);
    localparam logic [7:0] ADDR_TIMER1 = 8'h02;
    localparam logic [7:0] ADDR_TIMER2 = 8'h03;
    localparam logic [7:0] ADDR_CTRL   = 8'h04;

    logic [7:0] addr_q;
    logic       mask1_q;
    logic       mask2_q;
    logic       ft1_q;
    logic       ft2_q;

    logic       addr_wr_c;
    logic       data_wr_c;
    logic       ctrl_wr_c;
    logic       irq_clr_c;
    logic [7:0] status_c;

    // Data writes decode against the address latched before this edge.
    always_comb begin
        addr_wr_c = host.wr && !host.a0;
        data_wr_c = host.wr && host.a0;
        ctrl_wr_c = data_wr_c && (addr_q == ADDR_CTRL);
        irq_clr_c = ctrl_wr_c && host.din[7];
        status_c  = {ft1_q | ft2_q, ft1_q, ft2_q, STATUS_LOW_BITS};
    end

    // Address latch and the write-only timer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= 8'h00;
            timer1_reg   <= '0;
            timer2_reg   <= '0;
            mask1_q      <= 1'b0;
            mask2_q      <= 1'b0;
            start_timer1 <= 1'b0;
            start_timer2 <= 1'b0;
        end else begin
            if (addr_wr_c) begin
                addr_q <= host.din;
            end
            if (data_wr_c && (addr_q == ADDR_TIMER1)) begin
                timer1_reg <= REG_TIMER_WIDTH'(host.din);
            end
            if (data_wr_c && (addr_q == ADDR_TIMER2)) begin
                timer2_reg <= REG_TIMER_WIDTH'(host.din);
            end
            if (ctrl_wr_c && !host.din[7]) begin
                mask1_q      <= host.din[6];
                mask2_q      <= host.din[5];
                start_timer2 <= host.din[1];
                start_timer1 <= host.din[0];
            end
        end
    end

    // Sticky flags; a new unmasked overflow wins over a simultaneous IRQ reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ft1_q <= 1'b0;
            ft2_q <= 1'b0;
            irq_n <= 1'b1;
        end else begin
            ft1_q <= (ft1_q && !irq_clr_c) || (timer1_overflow_pulse && !mask1_q);
            ft2_q <= (ft2_q && !irq_clr_c) || (timer2_overflow_pulse && !mask2_q);
            irq_n <= !(ft1_q || ft2_q);
        end
    end

    // Host read-back; the data port reads as all ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host.dout       <= 8'h00;
            host.dout_valid <= 1'b0;
        end else begin
            host.dout_valid <= host.rd;
            if (host.rd) begin
                host.dout <= host.a0 ? 8'hFF : status_c;
            end
        end
    end
endmodule
